adder_rr_arbiter: RTL

- Shares one 32-bit Han-Carlson prefix adder (HanCarlson) between NREQ requesters.
- Each requester presents an operand pair and an op (add or subtract) with a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The sum is registered into a single-entry response slot tagged with the requester id.
- The block sits between ALU issue ports and the shared adder datapath.

---
 rtl/adder_arb_pkg.sv | 23 ++
 rtl/adder_rr_arbiter_hancarlson.sv | 50 +++++
 rtl/adder_rr_arbiter_rr_grant.sv | 31 +++
 rtl/adder_rr_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated adder.
// Optional grant statistics are enabled with the ADDER_ARB_STATS_EN macro.
package adder_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int STAT_W   = 16;
    localparam int ID_MAX_W = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [DATA_W-1:0]   sum;
        logic                cout;
        logic                ovf;
    } rsp_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_hancarlson.sv
// Combinational Han-Carlson prefix adder: Kogge-Stone tree on odd bits,
// one extra level to fill in the even bits.
module HanCarlson #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_cout
);

    localparam int LVLS = $clog2(DATA_W);

    logic [DATA_W-1:0] w_p0;
    logic [DATA_W-1:0] w_gf;

    always_comb begin
        logic [DATA_W-1:0] g [0:LVLS+1];
        logic [DATA_W-1:0] p [0:LVLS+1];
        int d;
        g[0] = i_a & i_b;
        p[0] = i_a ^ i_b;
        // Fold the carry-in into bit 0 so every prefix already includes it
        g[0][0] = g[0][0] | (p[0][0] & i_cin);
        for (int l = 1; l <= LVLS; l++) begin
            d    = 1 << (l - 1);
            g[l] = g[l-1];
            p[l] = p[l-1];
            for (int i = 0; i < DATA_W; i++) begin
                if ((i % 2 == 1) && (i >= d)) begin
                    g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i-d]);
                    p[l][i] = p[l-1][i] & p[l-1][i-d];
                end
            end
        end
        g[LVLS+1] = g[LVLS];
        p[LVLS+1] = p[LVLS];
        for (int i = 2; i < DATA_W; i += 2) begin
            g[LVLS+1][i] = g[LVLS][i] | (p[LVLS][i] & g[LVLS][i-1]);
            p[LVLS+1][i] = p[LVLS][i] & p[LVLS][i-1];
        end
        w_p0 = p[0];
        w_gf = g[LVLS+1];
    end

    assign o_sum  = w_p0 ^ {w_gf[DATA_W-2:0], i_cin};
    assign o_cout = w_gf[DATA_W-1];

endmodule

// File: rtl/adder_rr_arbiter_rr_grant.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    always_comb begin
        int   j;
        logic found;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!found && i_req[j]) begin
                found = 1'b1;
                o_idx = IDW'(j);
            end
        end
        if (found && i_en) begin
            o_grant = NREQ'(1) << o_idx;
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// NREQ requesters share one Han-Carlson adder through a round-robin arbiter.
// Define ADDER_ARB_STATS_EN to add saturating per-requester grant counters.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ADDER_ARB_STATS_EN
    input  logic                 stat_clr,
    output logic [NREQ*16-1:0]   stat_grants,
`endif
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf
);

    logic              r_rsp_valid;
    rsp_t              r_rsp;
    logic [IDW-1:0]    r_ptr;

    logic              w_slot_free;
    logic              w_en;
    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_idx;
    logic              w_xfer;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_b_eff;
    logic              w_sub;
    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_ovf;

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    // Hold off grants while reset is asserted so no request sees an accept
    assign w_en        = w_slot_free && !rst;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_en),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);
    assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    assign w_a     = req_a[int'(w_idx)*DATA_W +: DATA_W];
    assign w_b     = req_b[int'(w_idx)*DATA_W +: DATA_W];
    assign w_sub   = req_sub[w_idx];
    assign w_b_eff = (w_sub == OP_SUB) ? ~w_b : w_b;

    HanCarlson #(
        .DATA_W (DATA_W)
    ) u_adder (
        .i_a    (w_a),
        .i_b    (w_b_eff),
        .i_cin  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_ovf = (w_a[DATA_W-1] == w_b_eff[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_rsp_valid <= 1'b1;
            r_rsp.id    <= ID_MAX_W'(w_idx);
            r_rsp.sum   <= w_sum;
            r_rsp.cout  <= w_cout;
            r_rsp.ovf   <= w_ovf;
            r_ptr       <= w_ptr_nxt;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = IDW'(r_rsp.id);
    assign rsp_sum   = r_rsp.sum;
    assign rsp_cout  = r_rsp.cout;
    assign rsp_ovf   = r_rsp.ovf;

`ifdef ADDER_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [NREQ];

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i] && req_valid[i]) begin
                    r_stat[i] <= sat_inc(r_stat[i]);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        assign stat_grants[gi*STAT_W +: STAT_W] = r_stat[gi];
    end
`endif

endmodule
